// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID/EX/M hazard inputs and stage stall/flush controls.
// Latency: none, this is a pure signal grouping.
// Backpressure: stalls flow from controller to pipeline; the pipeline never backpressures the controller.
interface hazard_stall_ctrl_if;

    // Decode-stage instruction description
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_WantRs;
    logic       ID_WantRt;
    logic       ID_IsMulDiv;
    logic       ID_IsDiv;
    logic       ID_ReadsHiLo;

    // Execute / memory stage status
    logic       EX_MemRead;
    logic [4:0] EX_Rt;
    logic       IF_MemBusy;
    logic       M_MemBusy;
    logic       M_Exception;

    // Stage controls produced by the controller
    logic       IF_Stall;
    logic       ID_Stall;
    logic       EX_Stall;
    logic       M_Stall;
    logic       ID_Flush;
    logic       EX_Flush;
    logic       ExcRedirect;
    logic       HiLo_Start;
    logic       HiLo_Busy;

    // Pipeline side: describes its stages, obeys the stall/flush controls
    modport master (
        output ID_Rs, ID_Rt, ID_WantRs, ID_WantRt, ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo,
        output EX_MemRead, EX_Rt, IF_MemBusy, M_MemBusy, M_Exception,
        input  IF_Stall, ID_Stall, EX_Stall, M_Stall, ID_Flush, EX_Flush,
        input  ExcRedirect, HiLo_Start, HiLo_Busy
    );

    // Controller side
    modport slave (
        input  ID_Rs, ID_Rt, ID_WantRs, ID_WantRt, ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo,
        input  EX_MemRead, EX_Rt, IF_MemBusy, M_MemBusy, M_Exception,
        output IF_Stall, ID_Stall, EX_Stall, M_Stall, ID_Flush, EX_Flush,
        output ExcRedirect, HiLo_Start, HiLo_Busy
    );

endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller: load-use, HI/LO busy sequencing and deferred exception flush.
// Latency: all controls combinational from inputs and current state (0 cycles).
// Backpressure: a busy data memory stalls every stage; hazards stall ID and IF only.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32   // must be >= MULT_CYCLES so the counter width covers both
) (
    input  logic                CLK,
    input  logic                RST,
    hazard_stall_ctrl_if.slave  hz
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic {
        EXC_IDLE = 1'b0,
        EXC_PEND = 1'b1
    } exc_state_t;

    exc_state_t       exc_state_q;
    logic [CNT_W-1:0] hilo_cnt_q;
    logic [CNT_W-1:0] hilo_cnt_d;

    logic m_stall;
    logic ex_stall;
    logic id_stall;
    logic load_use;
    logic hilo_haz;
    logic hilo_busy;
    logic flush;
    logic hilo_start;
    logic rs_hit;
    logic rt_hit;

    // Hazard detection and the stall chain, M outward to IF
    always_comb begin
        rs_hit    = hz.ID_WantRs && (hz.ID_Rs == hz.EX_Rt);
        rt_hit    = hz.ID_WantRt && (hz.ID_Rt == hz.EX_Rt);
        // A load to r0 never produces a value anyone can depend on
        load_use  = hz.EX_MemRead && (hz.EX_Rt != 5'd0) && (rs_hit || rt_hit);
        hilo_busy = (hilo_cnt_q != '0);
        // Both a new mul/div and any HI/LO access must wait for the unit to drain
        hilo_haz  = hilo_busy && (hz.ID_IsMulDiv || hz.ID_ReadsHiLo);
        m_stall   = hz.M_MemBusy;
        ex_stall  = m_stall;
        id_stall  = ex_stall || load_use || hilo_haz;
    end

    // Flush fires only once M is free; a pending exception is remembered across stalls
    always_comb begin
        flush = 1'b0;
        case (exc_state_q)
            EXC_IDLE: flush = hz.M_Exception && !m_stall;
            EXC_PEND: flush = !m_stall;
            default:  flush = 1'b0;
        endcase
    end

    // Launch only for an instruction that actually leaves ID this cycle and is not squashed
    always_comb begin
        hilo_start = hz.ID_IsMulDiv && !id_stall && !flush;
    end

    // HI/LO busy counter next state: load on launch, otherwise count down to zero and hold
    always_comb begin
        hilo_cnt_d = hilo_cnt_q;
        if (hilo_start) begin
            hilo_cnt_d = hz.ID_IsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (hilo_cnt_q != '0) begin
            hilo_cnt_d = hilo_cnt_q - CNT_W'(1);
        end
    end

    // HI/LO counter register; exceptions never touch it so launched ops always finish
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hilo_cnt_q <= '0;
        end else begin
            hilo_cnt_q <= hilo_cnt_d;
        end
    end

    // Exception FSM: park in PEND while M is stalled, return to IDLE on the flush cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exc_state_q <= EXC_IDLE;
        end else begin
            case (exc_state_q)
                EXC_IDLE: begin
                    if (hz.M_Exception && m_stall) begin
                        exc_state_q <= EXC_PEND;
                    end
                end
                EXC_PEND: begin
                    // New exceptions are ignored here; the older one owns the flush
                    if (!m_stall) begin
                        exc_state_q <= EXC_IDLE;
                    end
                end
                default: exc_state_q <= EXC_IDLE;
            endcase
        end
    end

    // Drive the stage controls
    always_comb begin
        hz.M_Stall     = m_stall;
        hz.EX_Stall    = ex_stall;
        hz.ID_Stall    = id_stall;
        hz.IF_Stall    = id_stall || hz.IF_MemBusy;
        hz.ID_Flush    = flush;
        hz.EX_Flush    = flush;
        hz.ExcRedirect = flush;
        hz.HiLo_Start  = hilo_start;
        hz.HiLo_Busy   = hilo_busy;
    end

`ifndef SYNTHESIS
    // A launch can never overlap a running operation, and a flush never launches
    always_ff @(posedge CLK) begin
        if (RST) begin
            assert (!(hilo_start && hilo_busy));
            assert (!(hilo_start && flush));
        end
    end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Central stall/flush controller for the 5-stage MIPS III pipeline. It drives the `ID_Stall`, `EX_Stall` and `ID_Flush` inputs of the ID/EX pipeline register and the equivalent controls of the other pipeline registers. It detects load-use hazards, sequences the multi-cycle HI/LO multiply/divide unit with a busy counter, and defers exception flushes until the memory stage is free. All hazard outputs are combinational from inputs and internal state; state updates on `CLK`.

## Interface
- `MULT_CYCLES`, default 4: cycles the HI/LO unit is busy after a MULT/MULTU launch.
- `DIV_CYCLES`, default 32: cycles the HI/LO unit is busy after a DIV/DIVU launch; must be ≥ `MULT_CYCLES`.
- `CLK` input 1: sole clock, rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `ID_Rs`, `ID_Rt` input 5 each: source registers of the instruction in ID.
- `ID_WantRs`, `ID_WantRt` input 1 each: the ID instruction reads Rs / Rt.
- `ID_IsMulDiv` input 1: the ID instruction is MULT/MULTU/DIV/DIVU.
- `ID_IsDiv` input 1: qualifies `ID_IsMulDiv` as a divide.
- `ID_ReadsHiLo` input 1: the ID instruction is MFHI/MFLO/MTHI/MTLO.
- `EX_MemRead` input 1: the instruction in EX is a load.
- `EX_Rt` input 5: load destination register in EX.
- `IF_MemBusy` input 1: instruction memory not ready.
- `M_MemBusy` input 1: data memory not ready.
- `M_Exception` input 1: the instruction in M raised an exception.
- `IF_Stall`, `ID_Stall`, `EX_Stall`, `M_Stall` output 1 each: hold the corresponding stage.
- `ID_Flush`, `EX_Flush` output 1 each: squash the ID and EX stages.
- `ExcRedirect` output 1: one-cycle strobe telling fetch to load the exception vector.
- `HiLo_Start` output 1: launch the HI/LO unit this cycle.
- `HiLo_Busy` output 1: the HI/LO unit is computing.

## Operation
**Stall chain** (evaluated in this order):
- `M_Stall = M_MemBusy`.
- `EX_Stall = M_Stall`.
- `ID_Stall = EX_Stall | LoadUse | HiLoHaz`.
- `IF_Stall = ID_Stall | IF_MemBusy`.

**Hazard terms:**
- `LoadUse = EX_MemRead & (EX_Rt != 0) & ((ID_WantRs & ID_Rs == EX_Rt) | (ID_WantRt & ID_Rt == EX_Rt))`.
- `HiLoHaz = HiLo_Busy & (ID_IsMulDiv | ID_ReadsHiLo)`.

**HI/LO counter:**
- Width is `$clog2(DIV_CYCLES+1)`; `HiLo_Busy = (count != 0)`.
- `HiLo_Start = ID_IsMulDiv & ~ID_Stall & ~ID_Flush`.
- On `HiLo_Start`, the counter loads `DIV_CYCLES` if `ID_IsDiv`, else `MULT_CYCLES`.
- Otherwise, if nonzero, it decrements by 1 each cycle. It never wraps below 0.
- The counter is not affected by exceptions: a launched operation always completes.

**Exception FSM**, states IDLE and PEND:
- IDLE, `M_Exception & ~M_Stall`: assert `ID_Flush`, `EX_Flush` and `ExcRedirect` this cycle; stay in IDLE.
- IDLE, `M_Exception & M_Stall`: go to PEND; no flush outputs.
- PEND, `M_Stall`: stay in PEND.
- PEND, `~M_Stall`: assert `ID_Flush`, `EX_Flush` and `ExcRedirect`; go to IDLE. `M_Exception` is ignored while in PEND.

**Flush/stall interaction:**
- A flush overrides `LoadUse` and `HiLoHaz`: the squashed ID instruction must not start HI/LO.
- Stall outputs are still driven while a flush is asserted.

## Timing
- All outputs are combinational from current inputs and state. There is no added latency.
- `HiLo_Start` is high for at most 1 cycle per instruction.
- After a launch at cycle t, `HiLo_Busy` is high in cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`. It is low at t+N+1.
- A HI/LO-dependent instruction in ID advances in the first cycle `HiLo_Busy` is low.
- Back-to-back MULT: the second MULT stalls N cycles, then launches in cycle t+N+1.
- Load-use stalls exactly 1 cycle, provided the load leaves EX that cycle. With `EX_Stall` high, the stall persists.
- Reset (`RST` low, asynchronous, any cycle, including mid-divide or in PEND):
  - counter = 0 and FSM = IDLE immediately;
  - all outputs are driven only by current inputs, so with quiet inputs every output is 0.
- Exception and `HiLo_Start` in the same cycle: the flush wins and `HiLo_Start` = 0.

## Test plan
- **Load-use:** `EX_MemRead=1`, `EX_Rt=5`, `ID_Rs=5`, `ID_WantRs=1` → `ID_Stall`=`IF_Stall`=1 for 1 cycle, `EX_Stall`=0. Repeat with `EX_Rt=0` → no stall.
- **Divide then MFLO:** DIV in ID at cycle 10 → `HiLo_Start`=1 at 10, `HiLo_Busy` cycles 11–42. MFLO arriving at 11 → `ID_Stall`=1 for cycles 11–42, advances at 43.
- **MULT then MULT:** default parameters → second launch exactly 5 cycles after the first; busy duration 4 each time.
- **Memory stall:** `M_MemBusy` high 3 cycles → `M_Stall`/`EX_Stall`/`ID_Stall`/`IF_Stall` all 1 for those 3 cycles; the HI/LO counter keeps decrementing.
- **Deferred exception:** `M_Exception` pulse with `M_MemBusy`=1 for 2 more cycles → no flush while busy. `ID_Flush`=`EX_Flush`=`ExcRedirect`=1 in the first non-busy cycle, for exactly 1 cycle. A same-cycle `ID_IsMulDiv` gives `HiLo_Start`=0.
- **Reset mid-op:** assert `RST`=0 at divide count 17, asynchronously between edges → `HiLo_Busy`=0 immediately. After release, MFHI in ID → no stall.
